// File: rtl/vrf_ld_queue.sv
// vrf_ld_queue
// Load-return buffer between the vector load unit's memory response path and
// the VRF write-port arbiter. Load beats {vd, eidx, data} are queued in a
// circular FIFO. While the FIFO is non-empty, ld_req is raised. Each cycle
// that ld_gnt is seen with a non-empty FIFO, one beat is popped onto the
// registered VRF write port.
//
// Optional feature (macro VRF_LDQ_LAST_EN): adds the input mem_last, which is
// stored per entry, and the registered output ld_done. ld_done pulses together
// with the vrf_we of a beat that was tagged last.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   nrst       asynchronous active-low reset; flushes the queue
//   mem_valid  load beat valid
//   mem_ready  queue can accept a beat (count != DEPTH)
//   mem_vd     destination vector register of the beat
//   mem_eidx   element index of the beat
//   mem_data   element data of the beat
//   ld_req     write-port request (count != 0)
//   ld_gnt     registered grant from the arbiter; lags ld_req by one cycle
//   vrf_we     VRF write enable, registered
//   vrf_waddr  VRF register index, registered
//   vrf_eidx   VRF element index, registered
//   vrf_wdata  VRF write data, registered
//
// DEPTH must be a power of two and at least 2, so the pointers wrap naturally.
module vrf_ld_queue #(
    parameter int DATA_W  = 32,
    parameter int VREG_AW = 5,
    parameter int EIDX_W  = 3,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               mem_valid,
    output logic               mem_ready,
    input  logic [VREG_AW-1:0] mem_vd,
    input  logic [EIDX_W-1:0]  mem_eidx,
    input  logic [DATA_W-1:0]  mem_data,
`ifdef VRF_LDQ_LAST_EN
    input  logic               mem_last,
    output logic               ld_done,
`endif
    output logic               ld_req,
    input  logic               ld_gnt,
    output logic               vrf_we,
    output logic [VREG_AW-1:0] vrf_waddr,
    output logic [EIDX_W-1:0]  vrf_eidx,
    output logic [DATA_W-1:0]  vrf_wdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic [VREG_AW-1:0] vd_mem   [DEPTH];
    logic [EIDX_W-1:0]  eidx_mem [DEPTH];
    logic [DATA_W-1:0]  data_mem [DEPTH];

    logic               push;
    logic               pop;

    logic               vld_p1;
    logic [VREG_AW-1:0] vd_p1;
    logic [EIDX_W-1:0]  eidx_p1;
    logic [DATA_W-1:0]  data_p1;

    // Both flags decode only the registered count. This keeps ld_gnt out of
    // the mem_ready path. A grant that arrives at an empty queue is stale and
    // is ignored.
    assign mem_ready = (count != CNT_W'(DEPTH));
    assign ld_req    = (count != '0);
    assign push      = mem_valid && mem_ready;
    assign pop       = ld_gnt && ld_req;

    // Entry storage is pure data, so it has no reset. A flush is done only by
    // clearing the pointers and the count.
    always_ff @(posedge clk) begin
        if (push) begin
            vd_mem[wr_ptr]   <= mem_vd;
            eidx_mem[wr_ptr] <= mem_eidx;
            data_mem[wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ---- stage p1: registered VRF write port ----
    // The address and data fields hold their values when no pop occurs.
    // They still reset to zero, because the write-port outputs have defined
    // reset values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_p1  <= 1'b0;
            vd_p1   <= '0;
            eidx_p1 <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= pop;
            if (pop) begin
                vd_p1   <= vd_mem[rd_ptr];
                eidx_p1 <= eidx_mem[rd_ptr];
                data_p1 <= data_mem[rd_ptr];
            end
        end
    end

`ifdef VRF_LDQ_LAST_EN
    logic last_mem [DEPTH];
    logic done_p1;

    always_ff @(posedge clk) begin
        if (push) last_mem[wr_ptr] <= mem_last;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) done_p1 <= 1'b0;
        else       done_p1 <= pop && last_mem[rd_ptr];
    end

    assign ld_done = done_p1;
`endif

    assign vrf_we    = vld_p1;
    assign vrf_waddr = vd_p1;
    assign vrf_eidx  = eidx_p1;
    assign vrf_wdata = data_p1;

endmodule
